// File: rtl/data_sram_responder_pkg.sv
// data_sram_responder_pkg: config window constants shared by the data SRAM responder
package data_sram_responder_pkg;
  localparam logic [15:0] CONF_BASE_HI = 16'hbfaf;
  localparam logic [15:0] CONF_LED_OFF = 16'h0000;
  localparam logic [15:0] CONF_SW_OFF = 16'h0004;
  localparam logic [15:0] CONF_TIMER_OFF = 16'h0008;
  localparam logic [15:0] CONF_NUM_OFF = 16'h000c;
  localparam logic [15:0] LED_RST = 16'hffff;
endpackage

// File: rtl/data_sram_responder_if.sv
// data_sram_responder_if: single-cycle data SRAM bus between CPU and responder
interface data_sram_responder_if;
  logic we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  modport master(output we, addr, wdata, input rdata);
  modport slave(input we, addr, wdata, output rdata);
endinterface

// File: rtl/data_sram_responder_sync_word_ram.sv
// sync_word_ram: word RAM with registered, read-first read port
module sync_word_ram #(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);
  logic [31:0] mem [2**AW];
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end
endmodule

// File: rtl/data_sram_responder.sv
// data_sram_responder: decodes CPU data accesses to word RAM or LED/switch/timer/num registers
module data_sram_responder
  import data_sram_responder_pkg::*;
#(
  parameter int          RAM_AW    = 10,
  parameter logic [31:0] CONF_BASE = {CONF_BASE_HI, 16'h0000},
  parameter logic [15:0] LED_INIT  = LED_RST
) (
  input  logic                        clk,
  input  logic                        resetn,
  data_sram_responder_if.slave        data_sram,
  input  logic [7:0]                  switch,
  output logic [15:0]                 led,
  output logic [31:0]                 num_data
);
  logic conf_hit, conf_hit_q;
  logic [15:0] off;
  logic [31:0] conf_rd, conf_rdata_q, ram_rdata, timer;
  logic [7:0] sw_meta, sw_sync;
  assign conf_hit = data_sram.addr[31:16] == CONF_BASE[31:16];
  assign off = data_sram.addr[15:0];
  // writes during reset must not reach the RAM either
  sync_word_ram #(.AW(RAM_AW)) u_ram (
    .clk(clk),
    .we(data_sram.we & resetn & ~conf_hit),
    .addr(data_sram.addr[RAM_AW+1:2]),
    .wdata(data_sram.wdata),
    .rdata(ram_rdata)
  );
  always_comb
    conf_rd = off == CONF_LED_OFF   ? {16'h0000, led} :
              off == CONF_SW_OFF    ? {24'h000000, sw_sync} :
              off == CONF_TIMER_OFF ? timer :
              off == CONF_NUM_OFF   ? num_data : 32'h0;
  // reset forces the select onto the zeroed config register so the RAM output is hidden
  always_ff @(posedge clk) begin
    if (!resetn) begin
      led <= LED_INIT;
      num_data <= 32'h0;
      timer <= 32'h0;
      sw_meta <= 8'h00;
      sw_sync <= 8'h00;
      conf_hit_q <= 1'b1;
      conf_rdata_q <= 32'h0;
    end else begin
      sw_meta <= switch;
      sw_sync <= sw_meta;
      conf_hit_q <= conf_hit;
      conf_rdata_q <= conf_rd;
      timer <= (data_sram.we && conf_hit && off == CONF_TIMER_OFF) ? data_sram.wdata : timer + 32'd1;
      if (data_sram.we && conf_hit && off == CONF_LED_OFF) led <= data_sram.wdata[15:0];
      if (data_sram.we && conf_hit && off == CONF_NUM_OFF) num_data <= data_sram.wdata;
    end
  end
  assign data_sram.rdata = conf_hit_q ? conf_rdata_q : ram_rdata;
endmodule

// File: tb/tb_data_sram_responder.sv
// tb_data_sram_responder: directed self-checking bench for data_sram_responder
module tb_data_sram_responder;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic [7:0] sw = 8'h00;
  logic [15:0] led;
  logic [31:0] num_data;
  int tests = 0;
  int fails = 0;
  data_sram_responder_if bus();
  data_sram_responder dut (
    .clk(clk),
    .resetn(resetn),
    .data_sram(bus),
    .switch(sw),
    .led(led),
    .num_data(num_data)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic put(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    bus.we = we;
    bus.addr = addr;
    bus.wdata = wdata;
  endtask
  task automatic test_reset;
    resetn = 1'b0;
    put(1'b0, 32'h0, 32'h0);
    tick;
    tick;
    tests++; if (bus.rdata !== 32'h0) begin fails++; $display("FAIL reset_rdata got %h want %h", bus.rdata, 32'h0); end
    tests++; if (led !== 16'hffff) begin fails++; $display("FAIL reset_led got %h want %h", led, 16'hffff); end
    tests++; if (num_data !== 32'h0) begin fails++; $display("FAIL reset_num got %h want %h", num_data, 32'h0); end
  endtask
  task automatic test_timer;
    resetn = 1'b1;
    put(1'b0, 32'hbfaf_0008, 32'h0);
    for (int k = 0; k <= 5; k++) begin
      tick;
      tests++; if (bus.rdata !== 32'(k)) begin fails++; $display("FAIL timer_count%0d got %h want %h", k, bus.rdata, 32'(k)); end
    end
    put(1'b1, 32'hbfaf_0008, 32'hffff_fffe);
    tick;
    tests++; if (bus.rdata !== 32'd6) begin fails++; $display("FAIL timer_rd_first got %h want %h", bus.rdata, 32'd6); end
    put(1'b0, 32'hbfaf_0008, 32'h0);
    tick;
    tests++; if (bus.rdata !== 32'hffff_fffe) begin fails++; $display("FAIL timer_load got %h want %h", bus.rdata, 32'hffff_fffe); end
    tick;
    tests++; if (bus.rdata !== 32'hffff_ffff) begin fails++; $display("FAIL timer_max got %h want %h", bus.rdata, 32'hffff_ffff); end
    tick;
    tests++; if (bus.rdata !== 32'h0) begin fails++; $display("FAIL timer_wrap got %h want %h", bus.rdata, 32'h0); end
  endtask
  task automatic test_ram;
    put(1'b1, 32'h1c00_0010, 32'hdead_beef);
    tick;
    put(1'b0, 32'h1c00_0010, 32'h0);
    tick;
    tests++; if (bus.rdata !== 32'hdead_beef) begin fails++; $display("FAIL ram_rw got %h want %h", bus.rdata, 32'hdead_beef); end
  endtask
  task automatic test_read_first;
    put(1'b1, 32'h1c00_0020, 32'h11);
    tick;
    put(1'b1, 32'h1c00_0020, 32'h22);
    tick;
    tests++; if (bus.rdata !== 32'h11) begin fails++; $display("FAIL ram_read_first got %h want %h", bus.rdata, 32'h11); end
    put(1'b0, 32'h1c00_0020, 32'h0);
    tick;
    tests++; if (bus.rdata !== 32'h22) begin fails++; $display("FAIL ram_reread got %h want %h", bus.rdata, 32'h22); end
  endtask
  task automatic test_alias;
    put(1'b1, 32'h1c00_0000, 32'ha5);
    tick;
    put(1'b1, 32'h1c00_0004, 32'h5a);
    tick;
    put(1'b0, 32'h1c00_1000, 32'h0);
    tick;
    tests++; if (bus.rdata !== 32'ha5) begin fails++; $display("FAIL ram_alias got %h want %h", bus.rdata, 32'ha5); end
    put(1'b0, 32'h1c00_1004, 32'h0);
    tick;
    tests++; if (bus.rdata !== 32'h5a) begin fails++; $display("FAIL ram_alias_next got %h want %h", bus.rdata, 32'h5a); end
  endtask
  task automatic test_config;
    put(1'b1, 32'hbfaf_0000, 32'h0000_1234);
    tick;
    tests++; if (led !== 16'h1234) begin fails++; $display("FAIL led_write got %h want %h", led, 16'h1234); end
    put(1'b0, 32'hbfaf_0000, 32'h0);
    tick;
    tests++; if (bus.rdata !== 32'h1234) begin fails++; $display("FAIL led_read got %h want %h", bus.rdata, 32'h1234); end
    sw = 8'h5a;
    put(1'b0, 32'h1c00_0000, 32'h0);
    tick;
    tick;
    tick;
    put(1'b0, 32'hbfaf_0004, 32'h0);
    tick;
    tests++; if (bus.rdata !== 32'h5a) begin fails++; $display("FAIL switch_read got %h want %h", bus.rdata, 32'h5a); end
    put(1'b1, 32'hbfaf_0004, 32'hffff_ffff);
    tick;
    put(1'b0, 32'hbfaf_0004, 32'h0);
    tick;
    tests++; if (bus.rdata !== 32'h5a) begin fails++; $display("FAIL switch_ro got %h want %h", bus.rdata, 32'h5a); end
    put(1'b1, 32'hbfaf_0100, 32'hcafe_f00d);
    tick;
    put(1'b0, 32'hbfaf_0100, 32'h0);
    tick;
    tests++; if (bus.rdata !== 32'h0) begin fails++; $display("FAIL unmapped_read got %h want %h", bus.rdata, 32'h0); end
    tests++; if (led !== 16'h1234 || num_data !== 32'h0) begin fails++; $display("FAIL unmapped_side_effect got led=%h num=%h want led=1234 num=0", led, num_data); end
  endtask
  task automatic test_reset_mid;
    put(1'b1, 32'hbfaf_0000, 32'h0);
    tick;
    put(1'b1, 32'hbfaf_000c, 32'h7);
    tick;
    tests++; if (led !== 16'h0 || num_data !== 32'h7) begin fails++; $display("FAIL mid_setup got led=%h num=%h want led=0000 num=7", led, num_data); end
    put(1'b0, 32'hbfaf_000c, 32'h0);
    tick;
    tests++; if (bus.rdata !== 32'h7) begin fails++; $display("FAIL num_read got %h want %h", bus.rdata, 32'h7); end
    resetn = 1'b0;
    put(1'b1, 32'hbfaf_000c, 32'h99);
    tick;
    tests++; if (led !== 16'hffff) begin fails++; $display("FAIL mid_led got %h want %h", led, 16'hffff); end
    tests++; if (num_data !== 32'h0) begin fails++; $display("FAIL mid_num got %h want %h", num_data, 32'h0); end
    tests++; if (bus.rdata !== 32'h0) begin fails++; $display("FAIL mid_rdata got %h want %h", bus.rdata, 32'h0); end
    resetn = 1'b1;
    put(1'b0, 32'hbfaf_000c, 32'h0);
    tick;
    tests++; if (bus.rdata !== 32'h0 || num_data !== 32'h0) begin fails++; $display("FAIL mid_write_lost got rdata=%h num=%h want 0", bus.rdata, num_data); end
  endtask
  initial begin
    put(1'b0, 32'h0, 32'h0);
    test_reset;
    test_timer;
    test_ram;
    test_read_first;
    test_alias;
    test_config;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
